spi_master: RTL

- Mode-0 (CPOL=0, CPHA=0), MSB-first, 8-bit SPI master.
- It is the initiator counterpart of the team's SPI slave and drives SCK, MOSI and active-low SSEL.
- SSEL can be held low across several bytes, so multi-byte messages can be exchanged with one slave.
- The host side uses a ready/start handshake and receives each reply byte with a one-cycle done strobe.

---
 rtl/spi_master.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/spi_master.sv
// spi_master
// ----------
// Mode-0 (CPOL=0, CPHA=0), MSB-first, 8-bit SPI master.
// A host hands over one byte per accepted start. SSEL can stay low across
// several bytes, so a multi-byte message can be exchanged with one slave.
// Each reply byte is reported with a one-cycle done strobe.
//
// Parameters
//   CLK_DIV : SCK half-period in clk cycles (4..255); SCK = clk/(2*CLK_DIV)
//   CS_IDLE : minimum clk cycles SSEL stays high after a message (>= 1)
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous reset, active high
//   start        byte request, accepted only while ready=1
//   tx_data      byte to send, captured on acceptance
//   tx_last      captured with start; 1 releases SSEL after this byte
//   release_msg  in HOLD, ends the message without sending another byte
//                (the message-release request; start wins if both are high)
//   ready        high in IDLE and HOLD
//   done         one-cycle pulse when a byte completes
//   rx_data      last received byte, held until the next done
//   SCK          SPI clock, idles low
//   MOSI         master data out
//   MISO         slave data in, asynchronous (2-FF synchronised)
//   SSEL         slave select, active low
module spi_master #(
    parameter int CLK_DIV = 8,
    parameter int CS_IDLE = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] tx_data,
    input  logic       tx_last,
    input  logic       release_msg,
    output logic       ready,
    output logic       done,
    output logic [7:0] rx_data,
    output logic       SCK,
    output logic       MOSI,
    input  logic       MISO,
    output logic       SSEL
);

    localparam logic [7:0] HALF_LAST = 8'(CLK_DIV - 1);
    localparam int         GAP_W     = (CS_IDLE > 1) ? $clog2(CS_IDLE) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CS_IDLE - 1);
    localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);

    typedef enum logic [2:0] {
        IDLE,
        XFER,
        HOLD,
        TEARDOWN,
        GAP
    } state_t;

    state_t           state;
    logic [7:0]       half_cnt;
    logic [2:0]       bit_cnt;
    logic [GAP_W-1:0] gap_cnt;
    // Only the bits still to be sent / already received are kept; the
    // current MOSI bit lives in the MOSI flop itself.
    logic [6:0]       tx_shift;
    logic [6:0]       rx_shift;
    logic             last_q;
    logic             miso_p0;
    logic             miso_p1;
    logic             accept;

    assign ready  = (state == IDLE) || (state == HOLD);
    assign accept = ready && start;

    // Stage p0 -> p1: MISO synchroniser
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            miso_p0 <= 1'b0;
            miso_p1 <= 1'b0;
        end else begin
            miso_p0 <= MISO;
            miso_p1 <= miso_p0;
        end
    end

    // Stage p1 -> FSM: serial engine
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            half_cnt <= 8'd0;
            bit_cnt  <= 3'd0;
            gap_cnt  <= '0;
            tx_shift <= 7'd0;
            rx_shift <= 7'd0;
            last_q   <= 1'b0;
            done     <= 1'b0;
            rx_data  <= 8'd0;
            SCK      <= 1'b0;
            MOSI     <= 1'b0;
            SSEL     <= 1'b1;
        end else begin
            done <= 1'b0;
            if (accept) begin
                // Same handling from IDLE and HOLD: timing restarts here.
                tx_shift <= tx_data[6:0];
                last_q   <= tx_last;
                MOSI     <= tx_data[7];
                SSEL     <= 1'b0;
                SCK      <= 1'b0;
                half_cnt <= 8'd0;
                bit_cnt  <= 3'd0;
                state    <= XFER;
            end else begin
                case (state)
                    IDLE: begin
                        SCK  <= 1'b0;
                        SSEL <= 1'b1;
                    end

                    XFER: begin
                        if (half_cnt == HALF_LAST) begin
                            half_cnt <= 8'd0;
                            if (!SCK) begin
                                SCK <= 1'b1;
                            end else begin
                                // Falling edge: capture the bit and move on.
                                SCK      <= 1'b0;
                                rx_shift <= {rx_shift[5:0], miso_p1};
                                if (bit_cnt == 3'd7) begin
                                    rx_data <= {rx_shift, miso_p1};
                                    done    <= 1'b1;
                                    MOSI    <= 1'b0;
                                    state   <= last_q ? TEARDOWN : HOLD;
                                end else begin
                                    bit_cnt  <= bit_cnt + 3'd1;
                                    MOSI     <= tx_shift[6];
                                    tx_shift <= {tx_shift[5:0], 1'b0};
                                end
                            end
                        end else begin
                            half_cnt <= half_cnt + 8'd1;
                        end
                    end

                    HOLD: begin
                        // No timeout: the slave stays selected until the
                        // host sends another byte or releases the message.
                        if (release_msg) begin
                            half_cnt <= 8'd0;
                            state    <= TEARDOWN;
                        end
                    end

                    TEARDOWN: begin
                        if (half_cnt == HALF_LAST) begin
                            SSEL    <= 1'b1;
                            gap_cnt <= '0;
                            state   <= GAP;
                        end else begin
                            half_cnt <= half_cnt + 8'd1;
                        end
                    end

                    GAP: begin
                        if (gap_cnt == GAP_LAST) begin
                            state <= IDLE;
                        end else begin
                            gap_cnt <= gap_cnt + GAP_ONE;
                        end
                    end

                    default: begin
                        state <= IDLE;
                        SSEL  <= 1'b1;
                        SCK   <= 1'b0;
                        MOSI  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
